// File: rtl/demux1x4_collector_if.sv
// demux1x4_collector_if: handshake/bus bundle for the serial-to-parallel collector.
// Serial side: in_bit/in_valid/in_ready plus clr. Parallel side: out_data/out_valid/out_ready.
// Status: lane_idx (demux select) and par_err.
// The master modport is the environment (source + consumer); the slave modport is the collector.
interface demux1x4_collector_if #(
  parameter int LANES = 4
);
  localparam int IDXW = $clog2(LANES);

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             clr;
  logic [LANES-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  lane_idx;
  logic             par_err;

  modport master (
    output in_bit, in_valid, clr, out_ready,
    input  in_ready, out_data, out_valid, lane_idx, par_err
  );

  modport slave (
    input  in_bit, in_valid, clr, out_ready,
    output in_ready, out_data, out_valid, lane_idx, par_err
  );
endinterface

// File: rtl/demux1x4_collector.sv
// demux1x4_collector: steers bit k of each serial word to lane k.
// The assembled LANES-bit word is presented in a registered output slot with valid/ready.
// Optional feature macro: DEMUX1X4_COLLECTOR_PARITY_EN.
//   When defined, one even-parity bit follows each word. That bit completes the word and
//   loads par_err. When undefined, the final data bit completes the word and par_err is 0.
// Reset: synchronous, active-low (rst_n).
module demux1x4_collector #(
  parameter int LANES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  demux1x4_collector_if.slave  bus
);

  localparam int IDXW = $clog2(LANES);

`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
  // Every data lane is staged; the parity bit is the one that completes the word.
  localparam int STGW = LANES;
`else
  // The final data bit goes straight into out_data, so only LANES-1 lanes are staged.
  localparam int STGW = LANES - 1;
`endif

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_PARITY  = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDXW-1:0]  lane_idx_q;
  logic [STGW-1:0]  staging_q;
  logic [LANES-1:0] out_data_q;
  logic             out_valid_q;
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
  logic             par_err_q;
`endif

  logic last_lane;
  logic completing;
  logic in_ready_c;
  logic accept;
  logic consume;

  // Handshake decode: which slot is being offered and whether it can be taken this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here, unconditionally)
    // so no latch is inferred.
    last_lane  = (lane_idx_q == IDXW'(LANES - 1));
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
    completing = (state_q == S_PARITY);
`else
    completing = (state_q == S_COLLECT) && last_lane;
`endif
    // A completing bit needs a free output slot (or one being drained this very cycle);
    // clr always refuses the offered bit.
    in_ready_c = !bus.clr && (!completing || !out_valid_q || bus.out_ready);
    accept     = bus.in_valid && in_ready_c;
    consume    = out_valid_q && bus.out_ready;
  end

  // Collector FSM: lane stepping, staging writes and the registered output slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: staging is a handful of flops, not a memory, so it is reset along with the
      // rest to keep a mid-word reset from leaking old bits into the next word.
      state_q     <= S_COLLECT;
      lane_idx_q  <= '0;
      staging_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      // Drain first; a completing bit below overrides this in the same cycle.
      if (consume) begin
        out_valid_q <= 1'b0;
      end

      if (bus.clr) begin
        state_q    <= S_COLLECT;
        lane_idx_q <= '0;
        staging_q  <= '0;
      end else if (accept) begin
        case (state_q)
          S_COLLECT: begin
            for (int k = 0; k < STGW; k++) begin
              if (lane_idx_q == IDXW'(k)) begin
                staging_q[k] <= bus.in_bit;
              end
            end
            if (!last_lane) begin
              lane_idx_q <= lane_idx_q + IDXW'(1);
            end else begin
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
              // Final data lane staged; lane_idx parks on the last lane until parity arrives.
              state_q <= S_PARITY;
`else
              out_data_q  <= {bus.in_bit, staging_q};
              out_valid_q <= 1'b1;
              lane_idx_q  <= '0;
              staging_q   <= '0;
`endif
            end
          end
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
          S_PARITY: begin
            out_data_q  <= staging_q;
            par_err_q   <= (^staging_q) ^ bus.in_bit;
            out_valid_q <= 1'b1;
            lane_idx_q  <= '0;
            staging_q   <= '0;
            state_q     <= S_COLLECT;
          end
`endif
          default: begin
            state_q <= S_COLLECT;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.lane_idx  = lane_idx_q;
`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
  assign bus.par_err   = par_err_q;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_demux1x4_collector.sv
// tb_demux1x4_collector: directed bench for demux1x4_collector (LANES = 4).
// Inputs change 1 time unit after a rising edge and outputs are sampled 1 unit later.
// Registered outputs are therefore read well clear of the edge that produced them.
module tb_demux1x4_collector;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  demux1x4_collector_if #(.LANES(4)) bus ();

  demux1x4_collector #(.LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for the coming edge and let combinational outputs settle.
  task automatic drive(input logic iv, input logic b, input logic orv, input logic cl);
    bus.in_valid  = iv;
    bus.in_bit    = b;
    bus.out_ready = orv;
    bus.clr       = cl;
    #1;
  endtask

  // Advance one edge; registered outputs are stable on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word lane 0 first, checking lane_idx and in_ready on each bit.
  task automatic send_word(input string tag, input logic [3:0] w, input logic orv);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], orv, 1'b0);
      check({tag, "_lane"}, 32'(bus.lane_idx), 32'(i));
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [3:0] stream [8];
    logic [3:0] word_a;
    logic [3:0] word_b;

    n_checks = 0;
    n_fail   = 0;

    // Reset
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_lane_idx", 32'(bus.lane_idx), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_par_err", 32'(bus.par_err), 32'd0);

`ifdef DEMUX1X4_COLLECTOR_PARITY_EN
    // Data 1,1,0,1 (0xB) plus parity 1: even parity holds.
    send_word("p0", 4'hB, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("p0_par_rdy", 32'(bus.in_ready), 32'd1);
    check("p0_par_lane", 32'(bus.lane_idx), 32'd3);
    check("p0_valid_before_par", 32'(bus.out_valid), 32'd0);
    tick();
    check("p0_valid", 32'(bus.out_valid), 32'd1);
    check("p0_data", 32'(bus.out_data), 32'hB);
    check("p0_par_err", 32'(bus.par_err), 32'd0);
    check("p0_lane_wrap", 32'(bus.lane_idx), 32'd0);
    // Same data, parity 0: error flagged.
    send_word("p1", 4'hB, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("p1_valid", 32'(bus.out_valid), 32'd1);
    check("p1_data", 32'(bus.out_data), 32'hB);
    check("p1_par_err", 32'(bus.par_err), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("p1_drained", 32'(bus.out_valid), 32'd0);
`else
    // Test 1: bits 1,0,1,1 with out_ready high give 4'b1101 for one cycle.
    send_word("t1", 4'hD, 1'b1);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data", 32'(bus.out_data), 32'hD);
    check("t1_lane_wrap", 32'(bus.lane_idx), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("t1_pulse_end", 32'(bus.out_valid), 32'd0);

    // Test 2: out_ready low, word 0x6 then 0x9 stalls on its final bit.
    send_word("t2a", 4'h6, 1'b0);
    check("t2a_valid", 32'(bus.out_valid), 32'd1);
    check("t2a_data", 32'(bus.out_data), 32'h6);
    word_b = 4'h9;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word_b[i], 1'b0, 1'b0);
      check("t2b_rdy", 32'(bus.in_ready), 32'd1);
      tick();
    end
    drive(1'b1, word_b[3], 1'b0, 1'b0);
    check("t2_stall_rdy", 32'(bus.in_ready), 32'd0);
    check("t2_stall_lane", 32'(bus.lane_idx), 32'd3);
    tick();
    check("t2_hold_data", 32'(bus.out_data), 32'h6);
    check("t2_hold_valid", 32'(bus.out_valid), 32'd1);
    check("t2_hold_lane", 32'(bus.lane_idx), 32'd3);
    // Consume 0x6 and load 0x9 on the same edge.
    drive(1'b1, word_b[3], 1'b1, 1'b0);
    check("t2_release_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    check("t2b_valid", 32'(bus.out_valid), 32'd1);
    check("t2b_data", 32'(bus.out_data), 32'h9);
    check("t2b_lane_wrap", 32'(bus.lane_idx), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("t2b_drained", 32'(bus.out_valid), 32'd0);

    // Test 3: two bits, then clr with a bit offered; next word is clean.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("t3_lane_pre_clr", 32'(bus.lane_idx), 32'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("t3_clr_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    check("t3_clr_lane", 32'(bus.lane_idx), 32'd0);
    check("t3_clr_valid", 32'(bus.out_valid), 32'd0);
    send_word("t3", 4'hA, 1'b1);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    check("t3_data", 32'(bus.out_data), 32'hA);

    // clr with a word pending leaves the output slot alone.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("t3_clr_keeps_valid", 32'(bus.out_valid), 32'd1);
    check("t3_clr_keeps_data", 32'(bus.out_data), 32'hA);

    // Test 4: reset after 3 bits with 0xA still pending.
    word_a = 4'h7;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word_a[i], 1'b0, 1'b0);
      tick();
    end
    check("t4_lane_pre_rst", 32'(bus.lane_idx), 32'd3);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t4_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t4_rst_data", 32'(bus.out_data), 32'd0);
    check("t4_rst_lane", 32'(bus.lane_idx), 32'd0);
    check("t4_rst_rdy", 32'(bus.in_ready), 32'd1);
    send_word("t4", 4'h5, 1'b1);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    check("t4_data", 32'(bus.out_data), 32'h5);

    // Test 5: continuous 0x3 then 0xC with out_ready high (first bit drains 0x5).
    stream[0] = 4'h3;
    stream[1] = 4'hC;
    for (int i = 0; i < 8; i++) begin
      word_a = stream[i / 4];
      drive(1'b1, word_a[i % 4], 1'b1, 1'b0);
      check("t5_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      check("t5_valid", 32'(bus.out_valid), ((i % 4) == 3) ? 32'd1 : 32'd0);
      if ((i % 4) == 3) begin
        check("t5_data", 32'(bus.out_data), 32'(stream[i / 4]));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("t5_drained", 32'(bus.out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against any accidental hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
